draw_sched: RTL
===============

DRAW_SCHED -- requirements
Module: draw_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, circle-job queue depth (power of two, 2..16).
REQ-002 SHALL have parameter SCR_W, default 160, screen width in pixels.
REQ-003 SHALL have parameter SCR_H, default 120, screen height in pixels.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  synchronous, active-high reset (1 = reset).
REQ-006 job_valid  in  1  circle job offered.
REQ-007 job_ready  out  1  queue can accept a job.
REQ-008 job_cx, job_cy, job_r  in  8 each  job centre x, centre y, radius.
REQ-009 job_colour  in  3  job colour.
REQ-010 clr_req  in  1  one-cycle pulse requesting a full-screen clear.
REQ-011 clr_colour  in  3  clear colour, sampled with clr_req.
REQ-012 circ_start  out  1  start to circle engine.
REQ-013 circ_cx, circ_cy, circ_r  out  8 each  current job geometry to engine.
REQ-014 circ_colour  out  3  current job colour to engine.
REQ-015 circ_finished  in  1  engine done.
REQ-016 circ_x  in  8, circ_y  in  7, circ_plot  in  1  engine pixel stream.
REQ-017 vga_x  out  8, vga_y  out  7, vga_colour  out  3, vga_plot  out  1  muxed pixel port.
REQ-018 busy  out  1  state != IDLE or queue non-empty or clear pending.
REQ-019 jobs_done  out  8  count of completed circles, wraps 255->0.

Function
REQ-020 Queue SHALL be a FIFO of {cx,cy,r,colour}; push when job_valid & job_ready; job_ready = (count < FIFO_DEPTH), from the registered count only.
REQ-021 When full, a same-cycle pop SHALL NOT make job_ready high in that cycle; the freed slot appears next cycle.
REQ-022 A clr_req pulse SHALL set clr_pend and latch clr_colour in any state; a second pulse while pending SHALL overwrite only the colour.
REQ-023 FSM states: IDLE, CLEAR, LOAD, DRAW, GAP.
REQ-024 IDLE: clr_pend -> CLEAR (clear has priority); else queue non-empty -> LOAD; else stay.
REQ-025 Entering CLEAR SHALL clear clr_pend and zero the x/y counters.
REQ-026 CLEAR: one pixel per cycle, vga_plot=1, vga_colour=latched clear colour; order column-major, y 0..SCR_H-1 inner, x 0..SCR_W-1 outer.
REQ-027 CLEAR SHALL take exactly SCR_W*SCR_H cycles (19200 by default), go to IDLE after pixel (SCR_W-1,SCR_H-1), and never be interrupted by jobs or clr_req.
REQ-028 LOAD (1 cycle): pop head into circ_cx/cy/r/colour registers -> DRAW.
REQ-029 DRAW: circ_start=1; vga_x/y/plot = circ_x/y/plot combinationally; vga_colour=circ_colour; circ_finished=1 -> GAP and jobs_done++.
REQ-030 circ_finished seen in the first DRAW cycle SHALL be honoured (zero-length circle).
REQ-031 GAP (1 cycle): circ_start=0, vga_plot=0 -> IDLE; guarantees start low at least 1 cycle between jobs.
REQ-032 circ_start SHALL be 1 only in DRAW.
REQ-033 clr_req arriving in LOAD/DRAW/GAP SHALL NOT abort the circle; the clear runs after returning to IDLE.
REQ-034 Outside CLEAR/DRAW: vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-035 Circle geometry registers SHALL hold their value outside LOAD.

Reset
REQ-036 rst_n=1 at a clock edge SHALL force IDLE, empty queue, clr_pend=0, x/y counters=0, jobs_done=0, geometry and colour registers=0, from any state including mid-CLEAR or mid-DRAW.
REQ-037 During and after reset: circ_start=0, vga_plot=0, busy=0, job_ready=1 from the first cycle after reset.

Verification
REQ-038 Reset mid-DRAW -> next cycle circ_start=0, busy=0, jobs_done=0, queued jobs discarded.
REQ-039 clr_req with clr_colour=3'b010 in IDLE -> 19200 consecutive vga_plot=1 cycles; first (0,0), second (0,1), last (159,119), colour 010; then IDLE.
REQ-040 Push 5 jobs back-to-back with FIFO_DEPTH=4 and engine held unfinished -> 4 accepted; job_ready=0 while full; 5th held until a pop.
REQ-041 Job (80,60,r=10,c=3'b100), engine pulses finished after 50 cycles -> circ_start high 50 cycles, 1 cycle low (GAP), jobs_done=1, vga mirrors engine during DRAW.
REQ-042 clr_req during DRAW with job queued -> circle completes, CLEAR runs next, then the queued job.
REQ-043 256 zero-length jobs (finished tied high) -> each takes 4 cycles (IDLE, LOAD, DRAW, GAP); jobs_done wraps to 0.

Source files
------------

// File: rtl/draw_sched.sv
// Drawing scheduler: queues circle jobs for an external circle engine and
// interleaves full-screen clears, multiplexing both pixel streams onto one VGA port.
module draw_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCR_W      = 160,
    parameter int SCR_H      = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [7:0] job_cx,
    input  logic [7:0] job_cy,
    input  logic [7:0] job_r,
    input  logic [2:0] job_colour,
    input  logic       clr_req,
    input  logic [2:0] clr_colour,
    output logic       circ_start,
    output logic [7:0] circ_cx,
    output logic [7:0] circ_cy,
    output logic [7:0] circ_r,
    output logic [2:0] circ_colour,
    input  logic       circ_finished,
    input  logic [7:0] circ_x,
    input  logic [6:0] circ_y,
    input  logic       circ_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic [7:0] jobs_done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    X_LAST = 8'(SCR_W - 1);
    localparam logic [6:0]    Y_LAST = 7'(SCR_H - 1);

    typedef struct packed {
        logic [7:0] cx;
        logic [7:0] cy;
        logic [7:0] r;
        logic [2:0] colour;
    } job_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAW,
        GAP
    } state_t;

    state_t        state;
    job_t          mem [FIFO_DEPTH];
    job_t          cur;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          clr_pend;
    logic [2:0]    pend_col;
    logic [2:0]    act_col;
    logic [7:0]    x_cnt;
    logic [6:0]    y_cnt;

    assign job_ready = (count < DEPTH);
    assign push      = job_valid & job_ready;
    assign pop       = (state == LOAD);

    // Job storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{cx: job_cx, cy: job_cy, r: job_r, colour: job_colour};
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // A pending clear keeps its own colour so a new request cannot recolour a running clear.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            clr_pend  <= 1'b0;
            pend_col  <= '0;
            act_col   <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            jobs_done <= '0;
            cur       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_pend) begin
                        state    <= CLEAR;
                        clr_pend <= 1'b0;
                        act_col  <= pend_col;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                    end else if (count != '0) begin
                        state <= LOAD;
                    end
                end
                CLEAR: begin
                    if (y_cnt == Y_LAST) begin
                        y_cnt <= '0;
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            state <= IDLE;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end else begin
                        y_cnt <= y_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    cur   <= mem[rd_ptr];
                    state <= DRAW;
                end
                DRAW: begin
                    if (circ_finished) begin
                        jobs_done <= jobs_done + 1'b1;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (clr_req) begin
                clr_pend <= 1'b1;
                pend_col <= clr_colour;
            end
        end
    end

    assign circ_start  = (state == DRAW);
    assign circ_cx     = cur.cx;
    assign circ_cy     = cur.cy;
    assign circ_r      = cur.r;
    assign circ_colour = cur.colour;
    assign busy        = (state != IDLE) || (count != '0) || clr_pend;

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        case (state)
            CLEAR: begin
                vga_x      = x_cnt;
                vga_y      = y_cnt;
                vga_colour = act_col;
                vga_plot   = 1'b1;
            end
            DRAW: begin
                vga_x      = circ_x;
                vga_y      = circ_y;
                vga_colour = cur.colour;
                vga_plot   = circ_plot;
            end
            default: ;
        endcase
    end

endmodule
